// File: rtl/down_counter_if.sv
// Command/status bundle of the loadable down counter.
// The controller drives the requests through the master modport and the counter owns the status outputs.
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_val, start, pause, stop,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, pause, stop,
    output count, busy, done, zero
  );
endinterface

// File: rtl/down_counter.sv
// Loadable, pausable down counter / interval timer with a registered terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload (periodic done); default build is one-shot.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_term_val;
  logic [1:0]       w_term_state;

`ifdef DOWN_COUNTER_RELOAD_EN
  assign w_term_val   = r_reload;
  assign w_term_state = S_RUN;
`else
  assign w_term_val   = C_ZERO;
  assign w_term_state = S_IDLE;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // load wins over start; starting from zero would never terminate
        if (bus.load) begin
          w_count_nxt  = bus.load_val;
          w_reload_nxt = bus.load_val;
        end else if (bus.start && (r_count != C_ZERO)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (bus.pause) begin
          w_state_nxt = S_HOLD;
        end else if (r_count == C_ONE) begin
          w_done_nxt  = 1'b1;
          w_count_nxt = w_term_val;
          w_state_nxt = w_term_state;
        end else if (r_count != C_ZERO) begin
          w_count_nxt = r_count - C_ONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (!bus.pause) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= C_ZERO;
      r_reload <= C_ZERO;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = (r_state == S_RUN) || (r_state == S_HOLD);
  assign bus.done  = r_done;
  assign bus.zero  = (r_count == C_ZERO);

  // count only ever descends from the last loaded value, and an active timer is never at zero
  a_count_le_reload: assert property (@(posedge clk) disable iff (!rst) r_count <= r_reload);
  a_busy_nonzero:    assert property (@(posedge clk) disable iff (!rst) bus.busy |-> !bus.zero);
  a_state_legal:     assert property (@(posedge clk) disable iff (!rst) r_state != 2'd3);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenario tables plus randomized traffic
// compared against a cycle-level behavioural model of the timer.
module tb_down_counter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  down_counter_if #(.WIDTH(4)) bus ();

  down_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ld; int lv; int st; int pa; int sp;
    int c;  int b;  int d;
  } step_t;

  // behavioural model: remaining count, last loaded value, running/paused flags
  int m_cnt, m_rel, m_active, m_paused, m_done;

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_active = 0; m_paused = 0; m_done = 0;
  endtask

  task automatic drive(int ld, int lv, int st, int pa, int sp);
    bus.load     = 1'(ld);
    bus.load_val = 4'(lv);
    bus.start    = 1'(st);
    bus.pause    = 1'(pa);
    bus.stop     = 1'(sp);
  endtask

  task automatic tick();
    @(posedge clk);
    m_done = 0;
    if (m_active == 0) begin
      if (bus.load) begin
        m_cnt = int'(bus.load_val);
        m_rel = m_cnt;
      end else if (bus.start && m_cnt != 0) begin
        m_active = 1;
        m_paused = 0;
      end
    end else if (bus.stop) begin
      m_active = 0;
    end else if (m_paused != 0) begin
      if (!bus.pause) m_paused = 0;
    end else if (bus.pause) begin
      m_paused = 1;
    end else if (m_cnt == 1) begin
      m_done = 1;
`ifdef DOWN_COUNTER_RELOAD_EN
      m_cnt = m_rel;
`else
      m_cnt = 0;
      m_active = 0;
`endif
    end else begin
      m_cnt = m_cnt - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b zero=%b, required 0 0 0 1",
               bus.count, bus.busy, bus.done, bus.zero);
    end
    rst = 1'b1;
    model_reset();
    drive(1, 7, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.count !== 4'd7 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: count=%0d busy=%b, required 7 1", bus.count, bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d busy=%b done=%b zero=%b, required 0 0 0 1",
               bus.count, bus.busy, bus.done, bus.zero);
    end
    #2 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stop_ignore();
    step_t seq [12] = '{
      '{1,5,0,0,0, 5,0,0}, '{0,0,1,0,0, 5,1,0}, '{0,0,0,0,0, 4,1,0},
      '{0,0,0,0,0, 3,1,0}, '{0,0,0,0,0, 2,1,0}, '{0,0,0,0,1, 2,0,0},
      '{0,0,0,0,0, 2,0,0}, '{1,0,0,0,0, 0,0,0}, '{0,0,1,0,0, 0,0,0},
      '{0,0,0,1,1, 0,0,0}, '{1,9,1,0,0, 9,0,0}, '{0,0,0,0,0, 9,0,0}
    };
    foreach (seq[i]) begin
      drive(seq[i].ld, seq[i].lv, seq[i].st, seq[i].pa, seq[i].sp);
      tick();
      n_checks++;
      if (bus.count !== 4'(seq[i].c) || bus.busy !== 1'(seq[i].b) || bus.done !== 1'(seq[i].d)
          || bus.zero !== (seq[i].c == 0)) begin
        n_fail++;
        $display("FAIL stop_ignore step %0d: count=%0d busy=%b done=%b zero=%b, required %0d %0d %0d %0d",
                 i, bus.count, bus.busy, bus.done, bus.zero, seq[i].c, seq[i].b, seq[i].d, seq[i].c == 0);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

`ifndef DOWN_COUNTER_RELOAD_EN
  task automatic test_one_shot();
    step_t seq [7] = '{
      '{1,5,0,0,0, 5,0,0}, '{0,0,1,0,0, 5,1,0}, '{0,0,0,0,0, 4,1,0},
      '{0,0,0,0,0, 3,1,0}, '{0,0,0,0,0, 2,1,0}, '{0,0,0,0,0, 1,1,0},
      '{0,0,0,0,0, 0,0,1}
    };
    foreach (seq[i]) begin
      drive(seq[i].ld, seq[i].lv, seq[i].st, seq[i].pa, seq[i].sp);
      tick();
      n_checks++;
      if (bus.count !== 4'(seq[i].c) || bus.busy !== 1'(seq[i].b) || bus.done !== 1'(seq[i].d)
          || bus.zero !== (seq[i].c == 0)) begin
        n_fail++;
        $display("FAIL one_shot step %0d: count=%0d busy=%b done=%b zero=%b, required %0d %0d %0d %0d",
                 i, bus.count, bus.busy, bus.done, bus.zero, seq[i].c, seq[i].b, seq[i].d, seq[i].c == 0);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL one_shot_after: done=%b count=%0d, required 0 0", bus.done, bus.count);
    end
  endtask

  task automatic test_pause();
    step_t seq [10] = '{
      '{1,4,0,0,0, 4,0,0}, '{0,0,1,0,0, 4,1,0}, '{0,0,0,0,0, 3,1,0},
      '{0,0,0,1,0, 3,1,0}, '{0,0,0,1,0, 3,1,0}, '{0,0,0,1,0, 3,1,0},
      '{0,0,0,0,0, 3,1,0}, '{0,0,0,0,0, 2,1,0}, '{0,0,0,0,0, 1,1,0},
      '{0,0,0,0,0, 0,0,1}
    };
    foreach (seq[i]) begin
      drive(seq[i].ld, seq[i].lv, seq[i].st, seq[i].pa, seq[i].sp);
      tick();
      n_checks++;
      if (bus.count !== 4'(seq[i].c) || bus.busy !== 1'(seq[i].b) || bus.done !== 1'(seq[i].d)) begin
        n_fail++;
        $display("FAIL pause step %0d: count=%0d busy=%b done=%b, required %0d %0d %0d",
                 i, bus.count, bus.busy, bus.done, seq[i].c, seq[i].b, seq[i].d);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_boundary();
    step_t seq [16] = '{
      '{1,1,0,0,0, 1,0,0},  '{0,0,1,0,0, 1,1,0},  '{0,0,0,0,0, 0,0,1},
      '{1,2,0,0,0, 2,0,0},  '{0,0,1,0,0, 2,1,0},  '{0,0,0,0,0, 1,1,0},
      '{0,0,0,0,1, 1,0,0},  '{0,0,0,0,0, 1,0,0},  '{0,0,1,0,0, 1,1,0},
      '{0,0,0,1,0, 1,1,0},  '{0,0,0,0,0, 1,1,0},  '{0,0,0,0,0, 0,0,1},
      '{1,15,0,0,0, 15,0,0}, '{0,0,1,0,0, 15,1,0}, '{1,3,1,0,0, 14,1,0},
      '{0,0,0,0,1, 14,0,0}
    };
    foreach (seq[i]) begin
      drive(seq[i].ld, seq[i].lv, seq[i].st, seq[i].pa, seq[i].sp);
      tick();
      n_checks++;
      if (bus.count !== 4'(seq[i].c) || bus.busy !== 1'(seq[i].b) || bus.done !== 1'(seq[i].d)
          || bus.zero !== (seq[i].c == 0)) begin
        n_fail++;
        $display("FAIL boundary step %0d: count=%0d busy=%b done=%b zero=%b, required %0d %0d %0d %0d",
                 i, bus.count, bus.busy, bus.done, bus.zero, seq[i].c, seq[i].b, seq[i].d, seq[i].c == 0);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask
`else
  task automatic test_reload();
    step_t seq [14] = '{
      '{1,3,0,0,0, 3,0,0}, '{0,0,1,0,0, 3,1,0}, '{0,0,0,0,0, 2,1,0},
      '{0,0,0,0,0, 1,1,0}, '{0,0,0,0,0, 3,1,1}, '{0,0,0,0,0, 2,1,0},
      '{0,0,0,0,0, 1,1,0}, '{0,0,0,0,0, 3,1,1}, '{0,0,0,0,1, 3,0,0},
      '{1,1,0,0,0, 1,0,0}, '{0,0,1,0,0, 1,1,0}, '{0,0,0,0,0, 1,1,1},
      '{0,0,0,0,0, 1,1,1}, '{0,0,0,0,1, 1,0,0}
    };
    foreach (seq[i]) begin
      drive(seq[i].ld, seq[i].lv, seq[i].st, seq[i].pa, seq[i].sp);
      tick();
      n_checks++;
      if (bus.count !== 4'(seq[i].c) || bus.busy !== 1'(seq[i].b) || bus.done !== 1'(seq[i].d)) begin
        n_fail++;
        $display("FAIL reload step %0d: count=%0d busy=%b done=%b, required %0d %0d %0d",
                 i, bus.count, bus.busy, bus.done, seq[i].c, seq[i].b, seq[i].d);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
            ($urandom_range(0, 11) == 0) ? 1 : 0);
      tick();
      n_checks++;
      if (bus.count !== 4'(m_cnt) || bus.busy !== 1'(m_active) || bus.done !== 1'(m_done)
          || bus.zero !== (m_cnt == 0)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: count=%0d busy=%b done=%b zero=%b, required %0d %0d %0d %0d",
                   i, bus.count, bus.busy, bus.done, bus.zero, m_cnt, m_active, m_done, m_cnt == 0);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_stop_ignore();
`ifndef DOWN_COUNTER_RELOAD_EN
    test_one_shot();
    test_pause();
    test_boundary();
`else
    test_reload();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
